// File: rtl/battleship_video_pkg.sv
// Shared types and constants for the battleship video path: cell-state codes,
// fixed overlay colours and the {col,row} cell address used by the board RAMs.
package battleship_video_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_MISS  = 2'd1,
        CELL_HIT   = 2'd2,
        CELL_SHIP  = 2'd3
    } cell_state_t;

    localparam logic [11:0] CURSOR_YELLOW = 12'hFF0;
    localparam logic [11:0] GRID_GREY     = 12'h888;
    localparam logic [11:0] BG_BLACK      = 12'h000;

    // Board index is always carried in two bits so up to four boards fit.
    localparam int BOARD_IDX_W = 2;

    typedef struct packed {
        logic [3:0] col;
        logic [3:0] row;
    } cell_addr_t;

endpackage

// File: rtl/board_renderer_if.sv
// Memory-side bus of the board renderer: per-board cell-RAM ports plus the
// shared sprite-ROM address and its four parallel colour outputs.
interface board_renderer_if #(
    parameter int BOARDS    = 2,
    parameter int TILE_LOG2 = 5
);
    logic [8*BOARDS-1:0]    cell_ram_addr;
    logic [2*BOARDS-1:0]    cell_ram_data;
    logic [2*TILE_LOG2-1:0] sprite_addr;
    logic [11:0]            empty_data;
    logic [11:0]            miss_data;
    logic [11:0]            hit_data;
    logic [11:0]            ship_data;

    modport master (
        output cell_ram_addr, sprite_addr,
        input  cell_ram_data, empty_data, miss_data, hit_data, ship_data
    );

    modport slave (
        input  cell_ram_addr, sprite_addr,
        output cell_ram_data, empty_data, miss_data, hit_data, ship_data
    );
endinterface

// File: rtl/board_renderer_blink_timer.sv
// Frame-counted cursor blink: counts frame_tick pulses and flips the phase
// every BLINK_FRAMES frames. Phase starts at 1 so the cursor is visible after reset.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    output logic blink_phase
);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    logic [CW-1:0] count_reg, count_next;
    logic          phase_reg, phase_next;

    always_comb begin
        count_next = count_reg;
        phase_next = phase_reg;
        if (frame_tick) begin
            if (count_reg == LAST) begin
                count_next = '0;
                phase_next = ~phase_reg;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            phase_reg <= 1'b1;
        end else begin
            count_reg <= count_next;
            phase_reg <= phase_next;
        end
    end

    assign blink_phase = phase_reg;
endmodule

// File: rtl/board_renderer.sv
// Three-stage tile-board pixel renderer: decode -> memory read -> composite.
// Define GRID_LINES_EN to draw grey grid lines on tile edges inside boards.
module board_renderer
    import battleship_video_pkg::*;
#(
    parameter int          BOARDS       = 2,
    parameter int          GRID_W       = 10,
    parameter int          GRID_H       = 10,
    parameter int          TILE_LOG2    = 5,
    parameter int          BOARD_STRIDE = 10,
    parameter int          ORIGIN_Y     = 96,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] BG_COLOR     = BG_BLACK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               vid_on,
    input  logic               frame_tick,
    input  logic               ghost_ship,
    input  logic [7:0]         cursor,
    input  logic [BOARDS-1:0]  cursor_en,
    input  logic [BOARDS-1:0]  ghost_en,
    board_renderer_if.master   mem,
    output logic [11:0]        screen_color,
    output logic               color_valid
);
    localparam logic [9:0] Y_LO = 10'(ORIGIN_Y);
    localparam logic [9:0] Y_HI = 10'(ORIGIN_Y + (GRID_H << TILE_LOG2));

    logic [9:0]             tcol, y_rel;
    logic                   in_tiles;
    logic [BOARDS-1:0]      board_hit;
    logic [3:0]             board_col [BOARDS];
    logic                   sel_valid;
    logic [BOARD_IDX_W-1:0] sel_board;
    logic [3:0]             sel_col, sel_row;
    logic                   cursor_hit;

    // y_rel wraps for rows above the tile region; it is only used under in_tiles.
    assign tcol     = pixel_x >> TILE_LOG2;
    assign y_rel    = pixel_y - Y_LO;
    assign in_tiles = (pixel_y >= Y_LO) && (pixel_y < Y_HI);
    assign sel_row  = 4'(y_rel >> TILE_LOG2);

    for (genvar gi = 0; gi < BOARDS; gi++) begin : g_board_decode
        localparam logic [9:0] B_LO = 10'(gi * BOARD_STRIDE);
        localparam logic [9:0] B_HI = 10'(gi * BOARD_STRIDE + GRID_W);
        assign board_hit[gi] = in_tiles && (tcol >= B_LO) && (tcol < B_HI);
        assign board_col[gi] = 4'(tcol - B_LO);
    end

    // Lowest-numbered matching board wins if strides ever overlap.
    always_comb begin
        sel_valid = 1'b0;
        sel_board = '0;
        sel_col   = '0;
        for (int i = BOARDS - 1; i >= 0; i--) begin
            if (board_hit[i]) begin
                sel_valid = 1'b1;
                sel_board = BOARD_IDX_W'(i);
                sel_col   = board_col[i];
            end
        end
    end

    assign cursor_hit = sel_valid && (sel_col == cursor[7:4]) && (sel_row == cursor[3:0]);

    // Stage 1: memory addresses and per-pixel flags.
    cell_addr_t             cell_addr_reg [BOARDS];
    logic [8*BOARDS-1:0]    cell_addr_flat;
    logic [2*TILE_LOG2-1:0] sprite_addr_reg;
    logic                   s1_vid, s1_in_board, s1_cursor, s1_ghost;
    logic [BOARD_IDX_W-1:0] s1_board;

    for (genvar gi = 0; gi < BOARDS; gi++) begin : g_cell_addr
        always_ff @(posedge clk) begin
            if (rst) begin
                cell_addr_reg[gi] <= '0;
            end else if (sel_valid && sel_board == BOARD_IDX_W'(gi)) begin
                cell_addr_reg[gi] <= '{col: sel_col, row: sel_row};
            end
        end
    end

    always_comb begin
        cell_addr_flat = '0;
        for (int i = 0; i < BOARDS; i++) begin
            cell_addr_flat[i*8 +: 8] = cell_addr_reg[i];
        end
    end

    assign mem.cell_ram_addr = cell_addr_flat;
    assign mem.sprite_addr   = sprite_addr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sprite_addr_reg <= '0;
            s1_vid          <= 1'b0;
            s1_in_board     <= 1'b0;
            s1_cursor       <= 1'b0;
            s1_ghost        <= 1'b0;
            s1_board        <= '0;
        end else begin
            if (sel_valid) begin
                sprite_addr_reg <= {y_rel[TILE_LOG2-1:0], pixel_x[TILE_LOG2-1:0]};
            end
            s1_vid      <= vid_on;
            s1_in_board <= sel_valid;
            s1_cursor   <= cursor_hit;
            s1_ghost    <= ghost_ship;
            s1_board    <= sel_board;
        end
    end

    // Stage 2: flags wait alongside the synchronous memory reads.
    logic                   s2_vid, s2_in_board, s2_cursor, s2_ghost;
    logic [BOARD_IDX_W-1:0] s2_board;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vid      <= 1'b0;
            s2_in_board <= 1'b0;
            s2_cursor   <= 1'b0;
            s2_ghost    <= 1'b0;
            s2_board    <= '0;
        end else begin
            s2_vid      <= s1_vid;
            s2_in_board <= s1_in_board;
            s2_cursor   <= s1_cursor;
            s2_ghost    <= s1_ghost;
            s2_board    <= s1_board;
        end
    end

`ifdef GRID_LINES_EN
    logic s1_grid, s2_grid;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_grid <= 1'b0;
            s2_grid <= 1'b0;
        end else begin
            s1_grid <= (pixel_x[TILE_LOG2-1:0] == '0) || (y_rel[TILE_LOG2-1:0] == '0);
            s2_grid <= s1_grid;
        end
    end
`endif

    // Stage 3: composite. Enables are frame-static, so they are used unaligned.
    logic        blink_phase;
    logic [3:0]  cur_en4, ghost_en4;
    logic [7:0]  cell_data8;
    cell_state_t cell_state;
    logic [11:0] color_next, color_reg;
    logic        valid_reg;

    blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .blink_phase (blink_phase)
    );

    assign cur_en4    = 4'(cursor_en);
    assign ghost_en4  = 4'(ghost_en);
    assign cell_data8 = 8'(mem.cell_ram_data);
    assign cell_state = cell_state_t'(cell_data8[{s2_board, 1'b0} +: 2]);

    always_comb begin
        color_next = BG_COLOR;
        if (s2_vid && s2_in_board) begin
            if (s2_cursor && cur_en4[s2_board] && blink_phase) begin
                color_next = CURSOR_YELLOW;
`ifdef GRID_LINES_EN
            end else if (s2_grid) begin
                color_next = GRID_GREY;
`endif
            end else if (s2_ghost && ghost_en4[s2_board]) begin
                color_next = mem.ship_data;
            end else begin
                case (cell_state)
                    CELL_EMPTY: color_next = mem.empty_data;
                    CELL_MISS:  color_next = mem.miss_data;
                    CELL_HIT:   color_next = mem.hit_data;
                    CELL_SHIP:  color_next = mem.ship_data;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_reg <= BG_COLOR;
            valid_reg <= 1'b0;
        end else begin
            color_reg <= color_next;
            valid_reg <= s2_vid;
        end
    end

    assign screen_color = color_reg;
    assign color_valid  = valid_reg;
endmodule

// File: doc/board_renderer.md
Name: board_renderer

Overview:
- Parametrised, pipelined tile-board pixel renderer for the battleship video subsystem. Generalises the fixed two-board screen painter to N boards of configurable grid and tile size.
- Sits between the VGA timing generator (pixel_x/pixel_y/vid_on) and the colour output stage.
- Drives per-board cell-RAM read addresses and a shared sprite-ROM address, then composites sprite, cursor and ghost-ship overlays.
- Adds a frame-counted blinking cursor and fixed-latency valid tracking.

Parameters:
- BOARDS, 2, number of boards rendered side by side (1..4)
- GRID_W, 10, cells per board row (<=16)
- GRID_H, 10, cells per board column (<=16)
- TILE_LOG2, 5, tile edge = 2**TILE_LOG2 pixels (32)
- BOARD_STRIDE, 10, horizontal tile offset between board origins
- ORIGIN_Y, 96, first pixel row of the tile region
- BLINK_FRAMES, 30, frames per cursor blink half-period
- BG_COLOR, 12'h000, colour outside boards and during blanking

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- vid_on  in  1  active video
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- ghost_ship  in  1  per-pixel ghost-ship flag, aligned with pixel_x/pixel_y
- cursor  in  8  {col[3:0], row[3:0]} of selected cell
- cursor_en  in  BOARDS  per-board cursor enable
- ghost_en  in  BOARDS  per-board ghost-ship enable
- cell_ram_addr  out  8*BOARDS  per-board {col[3:0], row[3:0]}, registered
- cell_ram_data  in  2*BOARDS  per-board cell state, 1-cycle synchronous read
- sprite_addr  out  2*TILE_LOG2  {tile_y, tile_x}, registered
- empty_data, miss_data, hit_data, ship_data  in  12 each  sprite ROM outputs, 1-cycle read
- screen_color  out  12  composited colour
- color_valid  out  1  screen_color corresponds to an active-video pixel

Behaviour:
- Reset state: cell_ram_addr 0, sprite_addr 0, screen_color BG_COLOR, color_valid 0, blink counter 0, blink_phase 1 (cursor visible). Pipeline valid and vid flags are cleared.
- Latency: a pixel presented in cycle N has its colour on screen_color in cycle N+3. There are no bubbles; throughput is one pixel per clock.
- Stage 1 (edge ending N): decodes the region.
  - in_tiles = ORIGIN_Y <= y < ORIGIN_Y + GRID_H<<TILE_LOG2.
  - tcol = x>>TILE_LOG2; board b = the b with b*BOARD_STRIDE <= tcol < b*BOARD_STRIDE + GRID_W; no match means background.
  - col = tcol - b*BOARD_STRIDE; row = (y-ORIGIN_Y)>>TILE_LOG2.
  - Drives cell_ram_addr[b] and sprite_addr. Unselected boards keep their previous address.
  - Delays vid_on, board index, hit-test flags and ghost_ship.
- Stage 2: memories return data. Cursor match and ghost flag travel with the pixel.
- Stage 3 priority, highest first:
  1. !vid_on gives BG_COLOR.
  2. Outside boards gives BG_COLOR.
  3. Cursor match && cursor_en[b] && blink_phase gives 12'hFF0.
  4. ghost_ship && ghost_en[b] gives ship_data.
  5. Otherwise select by cell state: 0 empty_data, 1 miss_data, 2 hit_data, 3 ship_data.
- color_valid is vid_on delayed by 3 cycles.
- Cursor col >= GRID_W or row >= GRID_H: no cursor drawn, no error.
- Blink: the counter increments on frame_tick. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles. With rst and frame_tick in the same cycle, rst wins.
- cursor_en and ghost_en are sampled in stage 3 and are unaligned by design, because they are frame-static.
- Reset mid-frame: outputs show BG_COLOR with color_valid 0 until 3 cycles after rst deasserts.
- Arithmetic: y-ORIGIN_Y is computed in 10 bits and used only when in_tiles. All comparisons are unsigned.

Optional Feature:
- GRID_LINES_EN defined: pixels with tile_x==0 or tile_y==0 inside a board render 12'h888. This has lower priority than the cursor and higher priority than ghost and cell sprites.
- Undefined: no grid lines; tile sprites are drawn edge to edge.

Decomposition:
- Package battleship_video_pkg holds:
  - the cell-state encodings EMPTY=0, MISS=1, HIT=2, SHIP=3;
  - colour constants CURSOR_YELLOW, GRID_GREY, BG_BLACK;
  - the cell_addr_t {col,row} struct.
- One sub-module, blink_timer: frame_tick counter plus the phase toggle, parameterised by BLINK_FRAMES.

Test Plan:
- Reset, then sweep pixel (0,96)..(639,415) with all RAM=0 -> ram addr board0 {0,0} at x=0..31; screen_color=empty_data exactly 3 cycles after each pixel; color_valid tracks vid_on.
- Board1 cell (3,2)=HIT, pixel (431,170) -> cell_ram_addr[15:8]=8'h32, screen_color=hit_data at N+3; pixel (319,170) maps to board0 col 9.
- cursor=8'h45, cursor_en=2'b01, pixel (140,260) -> 12'hFF0 for 30 frame_ticks, then cell sprite for the next 30, then yellow again.
- ghost_ship=1, ghost_en=2'b10 on a board0 pixel -> cell sprite shown (ghost ignored); the same pixel on board1 -> ship_data.
- cursor=8'hF0 (col 15) -> no yellow anywhere in the frame; pixel y=95 or y=416 -> BG_COLOR.
- Assert rst at a mid-line pixel with frame_tick high -> screen_color BG_COLOR, color_valid 0, blink counter 0, phase 1; rendering resumes after 3 cycles.
